// File: rtl/parking_gate_decoder.sv
// Parking gate direction decoder.
// Two light barriers (A street side, B lot side) are synchronised and
// debounced, then a direction FSM follows the crossing order and issues
// single-cycle entry (up) / exit (down) requests for the occupancy counter.
//
// Handshake: up/down are fire-and-forget one-cycle request pulses with no
// ready/acknowledge; the counter must accept a pulse in the cycle it is high.
// full/empty are level inputs sampled only on the completing transition.
module parking_gate_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sen_a,
    input  logic       sen_b,
    input  logic       full,
    input  logic       empty,
    output logic       up,
    output logic       down,
    output logic       busy,
    output logic       err,
    output logic [2:0] fsm_state
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] IN_A     = 3'd1;
    localparam logic [2:0] IN_AB    = 3'd2;
    localparam logic [2:0] IN_B     = 3'd3;
    localparam logic [2:0] OUT_B    = 3'd4;
    localparam logic [2:0] OUT_BA   = 3'd5;
    localparam logic [2:0] OUT_A    = 3'd6;
    localparam logic [2:0] WAIT_CLR = 3'd7;

    logic [1:0]    sync_a;
    logic [1:0]    sync_b;
    logic          da;
    logic          db;
    logic [DW-1:0] cnt_a;
    logic [DW-1:0] cnt_b;
    logic [TW-1:0] timer;
    logic [2:0]    state;
    logic [2:0]    next_state;
    logic          next_up;
    logic          next_down;
    logic          next_err;
    logic          timeout;
    logic [1:0]    pat;

    assign pat       = {da, db};
    assign fsm_state = state;

    // Two-flop synchronisers for the asynchronous barrier inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_a <= 2'b00;
            sync_b <= 2'b00;
        end else begin
            sync_a <= {sync_a[0], sen_a};
            sync_b <= {sync_b[0], sen_b};
        end
    end

    // Debounce A: flip only after DEBOUNCE_CYCLES consecutive disagreements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            da    <= 1'b0;
            cnt_a <= '0;
        end else if (sync_a[1] != da) begin
            if (cnt_a == DB_LAST) begin
                da    <= sync_a[1];
                cnt_a <= '0;
            end else begin
                cnt_a <= cnt_a + 1'b1;
            end
        end else begin
            cnt_a <= '0;
        end
    end

    // Debounce B: same rule as A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db    <= 1'b0;
            cnt_b <= '0;
        end else if (sync_b[1] != db) begin
            if (cnt_b == DB_LAST) begin
                db    <= sync_b[1];
                cnt_b <= '0;
            end else begin
                cnt_b <= cnt_b + 1'b1;
            end
        end else begin
            cnt_b <= '0;
        end
    end

    // Sequence timeout: the timer holds the cycles spent in the current
    // sequence state, so hitting TO_LAST means TIMEOUT_CYCLES cycles elapsed.
    assign timeout = (state != IDLE) && (state != WAIT_CLR) && (timer == TO_LAST);

    // Direction FSM next-state and pulse decode; timeout has top priority.
    always_comb begin
        next_state = state;
        next_up    = 1'b0;
        next_down  = 1'b0;
        next_err   = 1'b0;
        if (timeout) begin
            next_state = WAIT_CLR;
            next_err   = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    case (pat)
                        2'b10: next_state = IN_A;
                        2'b01: next_state = OUT_B;
                        2'b11: begin next_state = WAIT_CLR; next_err = 1'b1; end
                        default: next_state = state;
                    endcase
                end
                IN_A: begin
                    case (pat)
                        2'b11: next_state = IN_AB;
                        2'b00: next_state = IDLE;
                        2'b01: begin next_state = WAIT_CLR; next_err = 1'b1; end
                        default: next_state = state;
                    endcase
                end
                IN_AB: begin
                    case (pat)
                        2'b01: next_state = IN_B;
                        2'b10: next_state = IN_A;
                        2'b00: begin next_state = IDLE; next_err = 1'b1; end
                        default: next_state = state;
                    endcase
                end
                IN_B: begin
                    case (pat)
                        2'b00: begin
                            next_state = IDLE;
                            next_up    = !full;
                            next_err   = full;
                        end
                        2'b11: next_state = IN_AB;
                        2'b10: begin next_state = WAIT_CLR; next_err = 1'b1; end
                        default: next_state = state;
                    endcase
                end
                OUT_B: begin
                    case (pat)
                        2'b11: next_state = OUT_BA;
                        2'b00: next_state = IDLE;
                        2'b10: begin next_state = WAIT_CLR; next_err = 1'b1; end
                        default: next_state = state;
                    endcase
                end
                OUT_BA: begin
                    case (pat)
                        2'b10: next_state = OUT_A;
                        2'b01: next_state = OUT_B;
                        2'b00: begin next_state = IDLE; next_err = 1'b1; end
                        default: next_state = state;
                    endcase
                end
                OUT_A: begin
                    case (pat)
                        2'b00: begin
                            next_state = IDLE;
                            next_down  = !empty;
                            next_err   = empty;
                        end
                        2'b11: next_state = OUT_BA;
                        2'b01: begin next_state = WAIT_CLR; next_err = 1'b1; end
                        default: next_state = state;
                    endcase
                end
                WAIT_CLR: begin
                    if (pat == 2'b00) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

    // Timer restarts on any state change and is idle in IDLE and WAIT_CLR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= '0;
        end else if ((next_state != state) || (next_state == IDLE) || (next_state == WAIT_CLR)) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    // State and registered request/error pulses plus busy flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            up    <= 1'b0;
            down  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            up    <= next_up;
            down  <= next_down;
            err   <= next_err;
            busy  <= (next_state != IDLE);
        end
    end

endmodule

// File: tb/tb_parking_gate_decoder.sv
// Testbench for parking_gate_decoder: directed scenarios followed by random
// crossing sequences checked against a path-position reference model.
module tb_parking_gate_decoder;

    localparam int D   = 4;
    localparam int T   = 20;
    localparam int MAX = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sen_a;
    logic       sen_b;
    logic       full;
    logic       empty;
    logic       up;
    logic       down;
    logic       busy;
    logic       err;
    logic [2:0] fsm_state;

    int checks   = 0;
    int failures = 0;
    int n_up, n_down, n_err, n_busy;

    // random-phase storage and expected per-cycle outputs
    int   ph_pat[64];
    int   ph_len[64];
    int   ph_start[64];
    logic ph_full[64];
    logic ph_empty[64];
    int   nph;
    logic exp_up[MAX];
    logic exp_down[MAX];
    logic exp_err[MAX];
    logic exp_busy[MAX];
    logic ev_flag[MAX];
    logic ev_busy[MAX];

    parking_gate_decoder #(
        .DEBOUNCE_CYCLES(D),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sen_a    (sen_a),
        .sen_b    (sen_b),
        .full     (full),
        .empty    (empty),
        .up       (up),
        .down     (down),
        .busy     (busy),
        .err      (err),
        .fsm_state(fsm_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic clear_counts();
        n_up = 0; n_down = 0; n_err = 0; n_busy = 0;
    endtask

    // drive a sensor pattern for n cycles, counting output pulses
    task automatic hold(input logic a, input logic b, input int n);
        sen_a = a;
        sen_b = b;
        for (int i = 0; i < n; i++) begin
            tick();
            if (up)   n_up++;
            if (down) n_down++;
            if (err)  n_err++;
            if (busy) n_busy++;
            chk("up_down_exclusive", 32'(up & down), 32'd0);
        end
    endtask

    // position of pattern {a,b} along a crossing path (entry or exit)
    function automatic int path_idx(input bit entry, input int p);
        int ent[4];
        int ext[4];
        ent = '{0, 2, 3, 1};
        ext = '{0, 1, 3, 2};
        for (int i = 0; i < 4; i++) begin
            if (entry && ent[i] == p) return i;
            if (!entry && ext[i] == p) return i;
        end
        return -1;
    endfunction

    initial begin
        int cur, p, total, mode, pos, ni, ev, cb;
        logic fl, em;

        // reset
        rst_n = 1'b0; sen_a = 1'b0; sen_b = 1'b0; full = 1'b0; empty = 1'b0;
        clear_counts();
        repeat (3) tick();
        chk("reset_up", 32'(up), 0);
        chk("reset_down", 32'(down), 0);
        chk("reset_err", 32'(err), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_state_idle", 32'(fsm_state), 0);
        rst_n = 1'b1;
        hold(0, 0, 10);

        // normal entry: up exactly 7 edges after B falls
        clear_counts();
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
        hold(0, 0, 6);
        chk("entry_no_early_up", 32'(n_up), 0);
        chk("entry_busy_before", 32'(busy), 1);
        tick();
        chk("entry_up_edge7", 32'(up), 1);
        chk("entry_busy_edge7", 32'(busy), 0);
        chk("entry_down_edge7", 32'(down), 0);
        chk("entry_err_edge7", 32'(err), 0);
        clear_counts();
        hold(0, 0, 10);
        chk("entry_single_up", 32'(n_up), 0);
        chk("entry_no_err", 32'(n_err), 0);

        // normal exit, empty=0
        clear_counts(); empty = 1'b0;
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 12);
        chk("exit_down", 32'(n_down), 1);
        chk("exit_up", 32'(n_up), 0);
        chk("exit_err", 32'(n_err), 0);
        chk("exit_busy_end", 32'(busy), 0);

        // exit with empty=1
        clear_counts(); empty = 1'b1;
        hold(0, 1, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 12);
        chk("exit_empty_down", 32'(n_down), 0);
        chk("exit_empty_err", 32'(n_err), 1);
        empty = 1'b0;

        // backing out
        clear_counts();
        hold(1, 0, 10); hold(1, 1, 10); hold(1, 0, 10); hold(0, 0, 12);
        chk("back_up", 32'(n_up), 0);
        chk("back_down", 32'(n_down), 0);
        chk("back_err", 32'(n_err), 0);
        chk("back_busy_end", 32'(busy), 0);

        // entry with full=1
        clear_counts(); full = 1'b1;
        hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10); hold(0, 0, 12);
        chk("full_up", 32'(n_up), 0);
        chk("full_err", 32'(n_err), 1);
        full = 1'b0;

        // glitch reject
        clear_counts();
        hold(1, 0, 3); hold(0, 0, 10);
        chk("glitch_busy", 32'(n_busy), 0);
        chk("glitch_err", 32'(n_err), 0);

        // timeout: err after D+3+T edges
        clear_counts();
        hold(1, 0, D + 2 + T);
        chk("timeout_no_early_err", 32'(n_err), 0);
        chk("timeout_busy_before", 32'(busy), 1);
        tick();
        chk("timeout_err", 32'(err), 1);
        chk("timeout_busy_wait", 32'(busy), 1);
        clear_counts();
        hold(1, 0, 5);
        chk("timeout_wait_no_err", 32'(n_err), 0);
        chk("timeout_wait_busy", 32'(busy), 1);
        hold(0, 0, 10);
        chk("timeout_no_up", 32'(n_up), 0);
        chk("timeout_idle", 32'(busy), 0);

        // reset mid-sequence in IN_AB
        clear_counts();
        hold(1, 0, 10); hold(1, 1, 10);
        chk("midrst_busy_before", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_up", 32'(up), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_state", 32'(fsm_state), 0);
        sen_a = 1'b0; sen_b = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        clear_counts();
        hold(0, 0, 15);
        chk("midrst_after_pulses", 32'(n_up + n_down + n_err + n_busy), 0);

        // random phases; pattern p = {a,b}, every phase changes the pattern
        cur = 0; nph = 0; total = 0;
        for (int j = 0; j < 40; j++) begin
            do p = int'($urandom_range(0, 3)); while (p == cur);
            ph_pat[nph]   = p;
            ph_len[nph]   = int'($urandom_range(D + 4, 15));
            ph_full[nph]  = 1'($urandom_range(0, 1));
            ph_empty[nph] = 1'($urandom_range(0, 1));
            nph++;
            cur = p;
        end
        if (cur != 0) begin
            ph_pat[nph] = 0; ph_len[nph] = 15;
            ph_full[nph] = 1'b0; ph_empty[nph] = 1'b0;
            nph++;
        end else begin
            ph_len[nph - 1] += 12;
        end
        for (int j = 0; j < nph; j++) begin
            ph_start[j] = total;
            total += ph_len[j];
        end
        for (int c = 0; c < MAX; c++) begin
            exp_up[c] = 0; exp_down[c] = 0; exp_err[c] = 0;
            ev_flag[c] = 0; ev_busy[c] = 0;
        end

        // reference model: mode 0 idle, 1 entering, 2 leaving, 3 wait-clear
        mode = 0; pos = 0;
        for (int j = 0; j < nph; j++) begin
            p  = ph_pat[j];
            fl = ph_full[j];
            em = ph_empty[j];
            ev = ph_start[j] + D + 2;
            if (mode == 0) begin
                if (p == 2)      begin mode = 1; pos = 1; end
                else if (p == 1) begin mode = 2; pos = 1; end
                else if (p == 3) begin mode = 3; exp_err[ev] = 1; end
            end else if (mode == 3) begin
                if (p == 0) mode = 0;
            end else begin
                ni = path_idx(mode == 1, p);
                if (ni == 0) begin
                    if (pos == 3) begin
                        if (mode == 1) begin
                            if (fl) exp_err[ev] = 1; else exp_up[ev] = 1;
                        end else begin
                            if (em) exp_err[ev] = 1; else exp_down[ev] = 1;
                        end
                    end else if (pos == 2) begin
                        exp_err[ev] = 1;
                    end
                    mode = 0;
                end else if (ni == pos + 1 || ni == pos - 1) begin
                    pos = ni;
                end else begin
                    mode = 3;
                    exp_err[ev] = 1;
                end
            end
            ev_flag[ev] = 1;
            ev_busy[ev] = (mode != 0);
        end
        cb = 0;
        for (int c = 0; c < total; c++) begin
            if (ev_flag[c]) cb = int'(ev_busy[c]);
            exp_busy[c] = cb[0];
        end

        // drive random phases and compare every cycle
        for (int j = 0; j < nph; j++) begin
            sen_a = ph_pat[j][1];
            sen_b = ph_pat[j][0];
            full  = ph_full[j];
            empty = ph_empty[j];
            for (int k = 0; k < ph_len[j]; k++) begin
                tick();
                chk("rnd_up", 32'(up), 32'(exp_up[ph_start[j] + k]));
                chk("rnd_down", 32'(down), 32'(exp_down[ph_start[j] + k]));
                chk("rnd_err", 32'(err), 32'(exp_err[ph_start[j] + k]));
                chk("rnd_busy", 32'(busy), 32'(exp_busy[ph_start[j] + k]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/parking_gate_decoder.md
Name: parking_gate_decoder

Overview:
- Upstream stage of the parking occupancy counter.
- Watches two light-barrier sensors at the lot gate: A on the street side, B on the lot side, spaced so one car can block both.
- Synchronises and debounces both sensors, then runs a direction FSM on the crossing order.
- Sends single-cycle entry/exit requests to the counter's up/down request inputs and suppresses requests that would overflow or underflow the counter.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised sensor must differ from its debounced value before that value flips; must be ≥1.
- TIMEOUT_CYCLES, 1000: maximum cycles without a state change in any sequence state before the sequence is abandoned; must be ≥2.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- sen_a  in  1  street-side barrier, asynchronous; 1 = beam blocked.
- sen_b  in  1  lot-side barrier, asynchronous; 1 = beam blocked.
- full  in  1  counter at maximum; blocks up.
- empty  in  1  counter at zero; blocks down.
- up  out  1  one-cycle entry request.
- down  out  1  one-cycle exit request.
- busy  out  1  FSM not in IDLE.
- err  out  1  one-cycle pulse on an invalid sequence, a timeout, or a suppressed request.

Behaviour:
- Reset: sync flops, debounced values da/db, debounce counters and timer clear to 0; state = IDLE; up = down = busy = err = 0.
- Reset mid-sequence discards the sequence; no pulse is issued.
- Sync: 2 flops per sensor.
- Debounce: a per-sensor counter counts consecutive cycles where synced ≠ debounced. It clears when they match. On the DEBOUNCE_CYCLES-th consecutive edge the debounced value flips and the counter clears.
- Debounce effect: glitches shorter than DEBOUNCE_CYCLES cycles are never seen by the FSM.
- FSM: 8 states, registered. It evaluates (da,db) every cycle. Any (da,db) combination not listed for a state means stay.
- IDLE: (1,0) → IN_A; (0,1) → OUT_B; (1,1) → WAIT_CLR + err.
- IN_A: (1,1) → IN_AB; (0,0) → IDLE, silent abort; (0,1) → WAIT_CLR + err.
- IN_AB: (0,1) → IN_B; (1,0) → IN_A, car backing out; (0,0) → IDLE + err.
- IN_B: (0,0) → IDLE; up = 1 if full = 0, else err = 1 and no up. (1,1) → IN_AB. (1,0) → WAIT_CLR + err.
- OUT_B / OUT_BA / OUT_A: mirror image of the IN states with A and B swapped. OUT_A with (0,0) → IDLE; down = 1 if empty = 0, else err.
- WAIT_CLR: (0,0) → IDLE; no timeout applies.
- Timer: clears on every state change and whenever the state is IDLE or WAIT_CLR. In other states it increments each cycle. When it reaches TIMEOUT_CYCLES → WAIT_CLR + err.
- Timeout priority: timeout wins over a simultaneous sensor transition.
- Outputs: up, down and err are registered alongside the state and are high for exactly one cycle. up and down are never high together. busy = (state ≠ IDLE), registered.
- Latency: a raw sensor edge held stable reaches the FSM input after DEBOUNCE_CYCLES+2 edges. The resulting up/down/err is high in the cycle after edge DEBOUNCE_CYCLES+3.
- full/empty are sampled only on the completing transition; changes mid-sequence have no effect.

Test Plan:
- Normal entry (DEBOUNCE_CYCLES=4): A=1 (10 cyc), A=B=1 (10), B=1 only (10), all clear. Required: exactly one up pulse, high in the cycle after the 7th edge from B falling; busy returns to 0 in that same cycle; no down, no err.
- Normal exit: B, B+A, A, clear with empty=0 → one down pulse. Repeat with empty=1 → err pulse, no down.
- Backing out: A, A+B, A, clear → no up, no down, no err; busy ends in 0. Entry with full=1 at completion → err pulse, no up.
- Glitch reject: 3-cycle pulse on sen_a in IDLE (DEBOUNCE_CYCLES=4) → state stays IDLE, busy stays 0.
- Timeout (TIMEOUT_CYCLES=20): hold A=1 only → err pulse after 20 cycles in IN_A, state WAIT_CLR. Release A → IDLE and no up.
- Reset mid-sequence: assert rst_n=0 while in IN_AB → outputs 0 immediately, state IDLE; no pulse after release with sensors clear.
